ccd_frame_capture: RTL and testbench

Front-end capture block: converts the camera's raw Bayer pixel stream (FVAL/LVAL framing) into the qualified pixel stream consumed by the image processing pipeline: 12-bit data, a data-valid strobe, X/Y raster coordinates, and a frame counter. Sits between the camera pin interface and the grayscale/Sobel stage and drives its iDATA, iDVAL, iX_Cont and iY_Cont inputs. Adds start/stop control so capture always begins and ends on whole-frame boundaries.

---
 rtl/ccd_frame_capture.sv | 143 ++++++++++++++
 tb/tb_ccd_frame_capture.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccd_frame_capture.sv
// ccd_frame_capture
//   Converts the raw sensor stream (FVAL/LVAL framing) into a qualified pixel
//   stream with raster coordinates and a completed-frame counter. Capture is
//   started/stopped only on whole-frame boundaries.
//
// Ports
//   iCLK        pixel clock, all logic on the rising edge
//   iRST        asynchronous active-high reset
//   iDATA       raw Bayer pixel from the sensor
//   iFVAL       sensor frame valid
//   iLVAL       sensor line valid
//   iSTART      one-cycle pulse, request capture start
//   iEND        one-cycle pulse, request stop at the end of the current frame
//   oDATA       registered pixel
//   oDVAL       oDATA / oX_Cont / oY_Cont valid this cycle
//   oX_Cont     column of the pixel on oDATA
//   oY_Cont     row of the pixel on oDATA
//   oFrame_Cont completed captured frames (wraps)
//   oBusy       registered: high while armed, capturing or stopping
module ccd_frame_capture #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned V_ACTIVE = 960
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [11:0] iDATA,
    input  logic        iFVAL,
    input  logic        iLVAL,
    input  logic        iSTART,
    input  logic        iEND,
    output logic [11:0] oDATA,
    output logic        oDVAL,
    output logic [10:0] oX_Cont,
    output logic [10:0] oY_Cont,
    output logic [31:0] oFrame_Cont,
    output logic        oBusy
);

    localparam logic [10:0] XLast  = 11'(H_ACTIVE - 1);
    localparam logic [10:0] YLimit = 11'(V_ACTIVE);

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StCapture,
        StStopping
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] mDATA;
    logic        mFVAL, mLVAL;
    logic        mFVAL_d, mLVAL_d;
    logic [10:0] x_q, y_q;

    logic fval_rise, fval_fall, lval_fall;
    logic active, pix, clr;

    assign fval_rise = mFVAL & ~mFVAL_d;
    assign fval_fall = ~mFVAL & mFVAL_d;
    assign lval_fall = ~mLVAL & mLVAL_d;
    assign active    = (state_q == StCapture) || (state_q == StStopping);
    assign pix       = mFVAL && mLVAL && active && (y_q < YLimit);
    // Raster position restarts at every frame end and whenever capture is not running.
    assign clr       = fval_fall || (state_d == StIdle) || (state_d == StArmed);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                // iEND wins over a simultaneous iSTART.
                if (iSTART && !iEND) state_d = StArmed;
            end
            StArmed: begin
                if (iEND)           state_d = StIdle;
                else if (fval_rise) state_d = StCapture;
            end
            StCapture: begin
                // A stop request coinciding with the frame end has nothing left to wait for.
                if (fval_fall)  state_d = iEND ? StIdle : StArmed;
                else if (iEND)  state_d = StStopping;
            end
            StStopping: begin
                if (fval_fall) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            mDATA       <= '0;
            mFVAL       <= 1'b0;
            mLVAL       <= 1'b0;
            mFVAL_d     <= 1'b0;
            mLVAL_d     <= 1'b0;
            state_q     <= StIdle;
            x_q         <= '0;
            y_q         <= '0;
            oDATA       <= '0;
            oDVAL       <= 1'b0;
            oX_Cont     <= '0;
            oY_Cont     <= '0;
            oFrame_Cont <= '0;
            oBusy       <= 1'b0;
        end else begin
            mDATA   <= iDATA;
            mFVAL   <= iFVAL;
            mLVAL   <= iLVAL;
            mFVAL_d <= mFVAL;
            mLVAL_d <= mLVAL;
            state_q <= state_d;
            oBusy   <= (state_q != StIdle);
            oDVAL   <= pix;

            if (pix) begin
                oDATA   <= mDATA;
                oX_Cont <= x_q;
                oY_Cont <= y_q;
            end

            if (fval_fall && active) begin
                oFrame_Cont <= oFrame_Cont + 32'd1;
            end

            if (clr) begin
                x_q <= '0;
                y_q <= '0;
            end else if (pix) begin
                if (x_q == XLast) begin
                    x_q <= '0;
                    if (y_q < YLimit) y_q <= y_q + 11'd1;
                end else begin
                    x_q <= x_q + 11'd1;
                end
            end else if (lval_fall && (x_q != 11'd0)) begin
                // Short line: resync to the start of the next row.
                x_q <= '0;
                if (y_q < YLimit) y_q <= y_q + 11'd1;
            end
        end
    end

endmodule

// File: tb/tb_ccd_frame_capture.sv
// Bench for ccd_frame_capture: directed scenarios plus randomized frames,
// checked every cycle against a frame-level model of which pixels must appear.
module tb_ccd_frame_capture;

    localparam int unsigned H = 8;
    localparam int unsigned V = 4;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic [11:0] iDATA = '0;
    logic        iFVAL = 1'b0;
    logic        iLVAL = 1'b0;
    logic        iSTART = 1'b0;
    logic        iEND = 1'b0;
    logic [11:0] oDATA;
    logic        oDVAL;
    logic [10:0] oX_Cont;
    logic [10:0] oY_Cont;
    logic [31:0] oFrame_Cont;
    logic        oBusy;

    ccd_frame_capture #(
        .H_ACTIVE(H),
        .V_ACTIVE(V)
    ) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iDATA      (iDATA),
        .iFVAL      (iFVAL),
        .iLVAL      (iLVAL),
        .iSTART     (iSTART),
        .iEND       (iEND),
        .oDATA      (oDATA),
        .oDVAL      (oDVAL),
        .oX_Cont    (oX_Cont),
        .oY_Cont    (oY_Cont),
        .oFrame_Cont(oFrame_Cont),
        .oBusy      (oBusy)
    );

    initial forever #5 iCLK = ~iCLK;

    typedef struct {
        logic [11:0] d;
        int          x;
        int          y;
        longint      cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    bit          exp_v;
    longint      cyc = 0;
    int          checks = 0;
    int          fails = 0;
    int          seen = 0;
    logic [11:0] last_d;
    int          last_x, last_y;

    // Model state: capture requested, stop requested, current frame captured.
    bit          running = 1'b0;
    bit          stop_pending = 1'b0;
    bit          frame_cap = 1'b0;
    logic [31:0] frames_model = '0;
    bit          use_pattern = 1'b0;
    int          lens[8];

    always @(posedge iCLK) cyc <= cyc + 1;

    // Per-cycle compare of the output stream against the expected pixel queue.
    always @(negedge iCLK) begin
        if (!iRST) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                cur = exp_q.pop_front();
                checks++;
                fails++;
                $display("FAIL pixel_missing cyc=%0d got=none expected x=%0d y=%0d d=%0d",
                         cyc, cur.x, cur.y, cur.d);
            end
            exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            checks++;
            if (oDVAL !== exp_v) begin
                fails++;
                $display("FAIL dval cyc=%0d got=%b expected=%b", cyc, oDVAL, exp_v);
            end
            if (exp_v) begin
                cur = exp_q.pop_front();
                checks++;
                if (oDATA !== cur.d || oX_Cont !== 11'(cur.x) || oY_Cont !== 11'(cur.y)) begin
                    fails++;
                    $display("FAIL pixel cyc=%0d got d=%0d x=%0d y=%0d expected d=%0d x=%0d y=%0d",
                             cyc, oDATA, oX_Cont, oY_Cont, cur.d, cur.x, cur.y);
                end
            end
            if (oDVAL === 1'b1) begin
                seen++;
                last_d = oDATA;
                last_x = int'(oX_Cont);
                last_y = int'(oY_Cont);
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_ctrl(input bit s, input bit e);
        if (e) begin
            if (!stop_pending) begin
                if (frame_cap) stop_pending = 1'b1;
                else           running = 1'b0;
            end
        end else if (s) begin
            running = 1'b1;
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        running      = 1'b0;
        stop_pending = 1'b0;
        frame_cap    = 1'b0;
        frames_model = '0;
    endtask

    task automatic hard_reset();
        @(negedge iCLK);
        iRST = 1'b1;
        iFVAL = 1'b0; iLVAL = 1'b0; iSTART = 1'b0; iEND = 1'b0; iDATA = '0;
        clear_model();
        repeat (2) @(negedge iCLK);
        iRST = 1'b0;
    endtask

    task automatic mid_reset();
        #2 iRST = 1'b1;
        #1;
        chk("rst_odata", longint'(oDATA), 0);
        chk("rst_odval", longint'(oDVAL), 0);
        chk("rst_ox", longint'(oX_Cont), 0);
        chk("rst_oy", longint'(oY_Cont), 0);
        chk("rst_frames", longint'(oFrame_Cont), 0);
        chk("rst_busy", longint'(oBusy), 0);
        clear_model();
        @(negedge iCLK);
        iRST = 1'b0;
    endtask

    task automatic frame(input int nl, input int ctl_line, input bit cs, input bit ce,
                         input int rst_line);
        logic [11:0] px;
        exp_t        ent;
        @(negedge iCLK);
        iFVAL = 1'b1; iLVAL = 1'b0; iSTART = 1'b0; iEND = 1'b0;
        frame_cap = running;
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < lens[l]; p++) begin
                @(negedge iCLK);
                px = use_pattern ? 12'(16 * l + p) : 12'($urandom);
                iLVAL = 1'b1; iDATA = px; iSTART = 1'b0; iEND = 1'b0;
                if (frame_cap && l < int'(V)) begin
                    ent.d = px; ent.x = p; ent.y = l; ent.cyc = cyc + 2;
                    exp_q.push_back(ent);
                end
                if (l == ctl_line && p == 0) begin
                    iSTART = cs; iEND = ce;
                    model_ctrl(cs, ce);
                end
                if (l == rst_line && p == 3) mid_reset();
            end
            repeat ($urandom_range(1, 2)) begin
                @(negedge iCLK);
                iLVAL = 1'b0; iSTART = 1'b0; iEND = 1'b0;
            end
        end
        @(negedge iCLK);
        iFVAL = 1'b0; iLVAL = 1'b0;
        if (frame_cap) begin
            frames_model = frames_model + 32'd1;
            if (stop_pending) begin
                running      = 1'b0;
                stop_pending = 1'b0;
            end
        end
        frame_cap = 1'b0;
    endtask

    task automatic gap(input int n, input bit s, input bit e);
        for (int i = 0; i < n; i++) begin
            @(negedge iCLK);
            iFVAL = 1'b0; iLVAL = 1'b0; iSTART = 1'b0; iEND = 1'b0;
            if (i == 2) begin
                iSTART = s; iEND = e;
                model_ctrl(s, e);
            end
        end
        chk("gap_frames", longint'(oFrame_Cont), longint'(frames_model));
        chk("gap_busy", longint'(oBusy), longint'(running));
    endtask

    task automatic full_lens();
        for (int i = 0; i < 8; i++) lens[i] = int'(H);
    endtask

    int s0;
    int nl, cl;
    bit rs, re;

    initial begin
        full_lens();
        #1 iRST = 1'b1;
        #1;
        chk("init_odata", longint'(oDATA), 0);
        chk("init_odval", longint'(oDVAL), 0);
        chk("init_ox", longint'(oX_Cont), 0);
        chk("init_oy", longint'(oY_Cont), 0);
        chk("init_frames", longint'(oFrame_Cont), 0);
        chk("init_busy", longint'(oBusy), 0);
        hard_reset();

        // 1: one patterned 4x8 frame
        use_pattern = 1'b1;
        gap(8, 1'b1, 1'b0);
        s0 = seen;
        frame(4, -1, 1'b0, 1'b0, -1);
        gap(8, 1'b0, 1'b0);
        chk("t1_dval_count", seen - s0, 32);
        chk("t1_frames", longint'(oFrame_Cont), 1);
        chk("t1_last_data", longint'(last_d), 55);
        chk("t1_last_x", last_x, 7);
        chk("t1_last_y", last_y, 3);

        // 2: start mid-frame, only the following frame is captured
        hard_reset();
        gap(8, 1'b0, 1'b0);
        s0 = seen;
        frame(4, 1, 1'b1, 1'b0, -1);
        gap(8, 1'b0, 1'b0);
        chk("t2_skipped_frame", seen - s0, 0);
        chk("t2_armed_busy", longint'(oBusy), 1);
        frame(4, -1, 1'b0, 1'b0, -1);
        gap(8, 1'b0, 1'b0);
        chk("t2_dval_count", seen - s0, 32);
        chk("t2_frames", longint'(oFrame_Cont), 1);

        // 3: six lines, line 2 short, surplus lines dropped
        hard_reset();
        lens[2] = 5;
        gap(8, 1'b1, 1'b0);
        s0 = seen;
        frame(6, -1, 1'b0, 1'b0, -1);
        gap(8, 1'b0, 1'b0);
        chk("t3_dval_count", seen - s0, 29);
        chk("t3_last_y", last_y, 3);
        chk("t3_last_x", last_x, 7);
        full_lens();

        // 4: continuous capture, stop requested in frame 2
        hard_reset();
        gap(8, 1'b1, 1'b0);
        s0 = seen;
        frame(4, -1, 1'b0, 1'b0, -1);
        gap(8, 1'b0, 1'b0);
        frame(4, 2, 1'b0, 1'b1, -1);
        gap(8, 1'b0, 1'b0);
        chk("t4_busy_after_stop", longint'(oBusy), 0);
        frame(4, -1, 1'b0, 1'b0, -1);
        gap(8, 1'b0, 1'b0);
        chk("t4_dval_count", seen - s0, 64);
        chk("t4_frames", longint'(oFrame_Cont), 2);

        // 5: simultaneous start and end while idle
        hard_reset();
        gap(8, 1'b1, 1'b1);
        chk("t5_busy", longint'(oBusy), 0);
        s0 = seen;
        frame(4, -1, 1'b0, 1'b0, -1);
        gap(8, 1'b0, 1'b0);
        chk("t5_dval_count", seen - s0, 0);

        // 6: reset mid-frame at line 1 pixel 3
        hard_reset();
        gap(8, 1'b1, 1'b0);
        frame(4, -1, 1'b0, 1'b0, 1);
        gap(8, 1'b0, 1'b0);
        s0 = seen;
        frame(4, -1, 1'b0, 1'b0, -1);
        gap(8, 1'b0, 1'b0);
        chk("t6_silent_after_rst", seen - s0, 0);
        gap(8, 1'b1, 1'b0);
        frame(4, -1, 1'b0, 1'b0, -1);
        gap(8, 1'b0, 1'b0);
        chk("t6_dval_count", seen - s0, 32);
        chk("t6_frames", longint'(oFrame_Cont), 1);

        // Randomized frames and control pulses
        hard_reset();
        use_pattern = 1'b0;
        for (int f = 0; f < 40; f++) begin
            nl = $urandom_range(1, 6);
            for (int i = 0; i < 8; i++) lens[i] = $urandom_range(1, 8);
            cl = (nl >= 2 && $urandom_range(0, 2) == 0) ? $urandom_range(1, nl - 1) : -1;
            rs = 1'($urandom_range(0, 1));
            re = ($urandom_range(0, 3) == 0);
            frame(nl, cl, rs, re, -1);
            rs = 1'($urandom_range(0, 1));
            re = ($urandom_range(0, 4) == 0);
            gap($urandom_range(8, 12), rs, re);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
